inst_fetch_queue: RTL and testbench

Instruction fetch stage for the single-cycle ARM datapath, sitting directly upstream of the instruction decoder. It owns the fetch PC, drives the combinational instruction memory, and buffers fetched {pc, instruction} pairs in a small FIFO. The FIFO feeds the decoder through a valid/ready handshake, so decode/execute stalls no longer freeze instruction memory addressing. Branch redirects from the branch mux flush the queue and restart fetch at the target.

---
 rtl/inst_fetch_queue.sv | 75 +++++++
 tb/tb_inst_fetch_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, addresses instruction memory and
// buffers {pc, inst} pairs in a small FIFO that feeds the decoder via valid/ready.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_inst,
  output logic [31:0]              dec_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [63:0]   mem_r [DEPTH];

  logic          pop_s;
  logic          push_s;

  assign pop_s  = (count_r != {CW{1'b0}}) & dec_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_s = fetch_en & ~redirect & ((count_r < CW'(DEPTH)) | pop_s);

  assign imem_addr = fetch_pc_r;
  assign dec_valid = (count_r != {CW{1'b0}});
  assign dec_pc    = mem_r[rd_ptr_r][63:32];
  assign dec_inst  = mem_r[rd_ptr_r][31:0];
  assign count     = count_r;

  // Fetch PC, queue pointers, occupancy and storage; reset beats redirect beats push/pop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc_r <= RESET_PC;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'd0;
      end
    end else if (redirect) begin
      fetch_pc_r <= {redirect_pc[31:2], 2'b00};
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {fetch_pc_r, imem_data};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
        fetch_pc_r      <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r      <= fetch_pc_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed phases push expected PCs,
// negedge monitors compare every decoder handshake against the queue head.
module tb_inst_fetch_queue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr, imem_data, dec_inst, dec_pc;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [2:0]  count;

  logic        hi_reset_n = 1'b0;
  logic        hi_fetch_en = 1'b0;
  logic        hi_dec_ready = 1'b0;
  logic        hi_redirect = 1'b0;
  logic [31:0] hi_imem_addr, hi_imem_data, hi_dec_inst, hi_dec_pc;
  logic        hi_dec_valid;
  logic [2:0]  hi_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_hi_q[$];

  always #5 clock = ~clock;

  // Instruction memory model: word at address A is A ^ 32'hA5A5_0000.
  assign imem_data    = imem_addr ^ 32'hA5A5_0000;
  assign hi_imem_data = hi_imem_addr ^ 32'hA5A5_0000;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .count(count)
  );

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clock(clock), .reset_n(hi_reset_n), .fetch_en(hi_fetch_en), .redirect(hi_redirect),
    .redirect_pc(32'd0), .imem_addr(hi_imem_addr), .imem_data(hi_imem_data),
    .dec_valid(hi_dec_valid), .dec_ready(hi_dec_ready), .dec_inst(hi_dec_inst),
    .dec_pc(hi_dec_pc), .count(hi_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fetch_en = 1'b0; dec_ready = 1'b0; redirect = 1'b0;
    step(); step();
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_valid", {31'd0, dec_valid}, 32'd0);
    chk("reset_imem_addr", imem_addr, 32'h0000_0000);
  endtask

  // Main-instance monitor: every accepted head entry must match the scoreboard.
  always @(negedge clock) begin
    if (reset_n && dec_valid && dec_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL deliver_unexpected: got pc %h expected none", dec_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dec_pc !== e || dec_inst !== (e ^ 32'hA5A5_0000)) begin
          fails++;
          $display("FAIL deliver: got pc %h inst %h expected pc %h inst %h",
                   dec_pc, dec_inst, e, e ^ 32'hA5A5_0000);
        end
      end
    end
  end

  // High-reset-PC instance monitor.
  always @(negedge clock) begin
    if (hi_reset_n && hi_dec_valid && hi_dec_ready) begin
      tests++;
      if (exp_hi_q.size() == 0) begin
        fails++;
        $display("FAIL hi_deliver_unexpected: got pc %h expected none", hi_dec_pc);
      end else begin
        logic [31:0] e;
        e = exp_hi_q.pop_front();
        if (hi_dec_pc !== e || hi_dec_inst !== (e ^ 32'hA5A5_0000)) begin
          fails++;
          $display("FAIL hi_deliver: got pc %h inst %h expected pc %h inst %h",
                   hi_dec_pc, hi_dec_inst, e, e ^ 32'hA5A5_0000);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Steady-state streaming: six fetches, each delivered the next cycle.
    do_reset();
    chk("reset_dec_pc", dec_pc, 32'd0);
    chk("reset_dec_inst", dec_inst, 32'd0);
    exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    reset_n = 1'b1; fetch_en = 1'b1; dec_ready = 1'b1;
    step();
    chk("first_valid", {31'd0, dec_valid}, 32'd1);
    chk("first_dec_pc", dec_pc, 32'h0);
    chk("steady_count", {29'd0, count}, 32'd1);
    repeat (5) step();
    chk("steady_count_late", {29'd0, count}, 32'd1);
    fetch_en = 1'b0;
    repeat (2) step();
    chk("drain_count", {29'd0, count}, 32'd0);
    chk("fetch_hold_addr", imem_addr, 32'h18);
    chk("p1_all_delivered", exp_q.size(), 32'd0);

    // Backpressure, then full-queue push+pop.
    do_reset();
    exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
    reset_n = 1'b1; fetch_en = 1'b1; dec_ready = 1'b0;
    step(); step();
    chk("stall_pc_early", dec_pc, 32'h0);
    repeat (8) step();
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_addr_hold", imem_addr, 32'h10);
    chk("stall_pc_late", dec_pc, 32'h0);
    chk("stall_inst_late", dec_inst, 32'hA5A5_0000);
    dec_ready = 1'b1;
    step();
    chk("pp_count1", {29'd0, count}, 32'd4);
    chk("pp_addr1", imem_addr, 32'h14);
    step();
    chk("pp_count2", {29'd0, count}, 32'd4);
    chk("pp_addr2", imem_addr, 32'h18);
    step(); step();
    chk("pp_addr4", imem_addr, 32'h20);
    fetch_en = 1'b0;
    repeat (4) step();
    chk("p2_drain_count", {29'd0, count}, 32'd0);
    chk("p2_all_delivered", exp_q.size(), 32'd0);

    // Redirect with count = 3 and a head handshake in the same cycle.
    do_reset();
    exp_q = '{32'h000, 32'h100, 32'h104};
    reset_n = 1'b1; fetch_en = 1'b1; dec_ready = 1'b0;
    repeat (3) step();
    chk("pre_redirect_count", {29'd0, count}, 32'd3);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; dec_ready = 1'b1;
    step();
    chk("redirect_count", {29'd0, count}, 32'd0);
    chk("redirect_valid", {31'd0, dec_valid}, 32'd0);
    chk("redirect_addr", imem_addr, 32'h100);
    redirect = 1'b0;
    step();
    chk("target_valid", {31'd0, dec_valid}, 32'd1);
    chk("target_dec_pc", dec_pc, 32'h100);
    step();
    fetch_en = 1'b0;
    repeat (2) step();
    chk("p3_all_delivered", exp_q.size(), 32'd0);

    // Reset and redirect together: reset wins and queued entries vanish.
    do_reset();
    reset_n = 1'b1; fetch_en = 1'b1; dec_ready = 1'b0;
    repeat (2) step();
    chk("pre_reset_count", {29'd0, count}, 32'd2);
    reset_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    chk("rr_count", {29'd0, count}, 32'd0);
    chk("rr_valid", {31'd0, dec_valid}, 32'd0);
    chk("rr_addr", imem_addr, 32'h0000_0000);
    chk("rr_dec_pc", dec_pc, 32'h0);
    chk("rr_dec_inst", dec_inst, 32'h0);
    redirect = 1'b0; fetch_en = 1'b0;
    step();

    // PC wrap past 2^32 from a high reset PC.
    chk("hi_reset_addr", hi_imem_addr, 32'hFFFF_FFF8);
    exp_hi_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    hi_reset_n = 1'b1; hi_fetch_en = 1'b1; hi_dec_ready = 1'b1;
    repeat (3) step();
    hi_fetch_en = 1'b0;
    repeat (2) step();
    chk("hi_wrap_addr", hi_imem_addr, 32'h0000_0004);
    chk("hi_all_delivered", exp_hi_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
